// File: rtl/riscv_dmem_responder_if.sv
// ============================================================================
// riscv_dmem_responder_if : core data-port bus (MemWrite/DataAdr/WriteData/ReadData)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface riscv_dmem_responder_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

`default_nettype wire

// File: rtl/riscv_dmem_responder.sv
// ============================================================================
// riscv_dmem_responder : word RAM plus timer/LED MMIO block for the core data port
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_dmem_responder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
    parameter int          LED_W     = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    riscv_dmem_responder_if.slave  bus,
    output logic [LED_W-1:0]       leds,
    output logic                   timer_irq
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES  = 32'(DEPTH * 4);
    localparam logic [1:0]  REG_MTIME  = 2'd0;
    localparam logic [1:0]  REG_CMP    = 2'd1;
    localparam logic [1:0]  REG_LED    = 2'd2;
    localparam logic [1:0]  REG_STATUS = 2'd3;

    logic [31:0]      mem [DEPTH];
    logic [31:0]      mtime;
    logic [31:0]      mtimecmp;
    logic [LED_W-1:0] led_reg;
    logic             irq;

    logic [31:0]      mmio_off;
    logic             ram_sel;
    logic             mmio_sel;
    logic [AW-1:0]    word_idx;
    logic [1:0]       reg_sel;
    logic             wr_ram;
    logic             wr_mmio;
    logic             match;
    logic             irq_clr;

    // Offset from the window base guards against bases that are not 16-byte aligned.
    assign mmio_off = bus.DataAdr - MMIO_BASE;
    assign ram_sel  = (bus.DataAdr < RAM_BYTES);
    assign mmio_sel = (bus.DataAdr >= MMIO_BASE) && (mmio_off < 32'd16);
    assign word_idx = bus.DataAdr[AW+1:2];
    assign reg_sel  = bus.DataAdr[3:2];
    assign wr_ram   = bus.MemWrite && ram_sel;
    assign wr_mmio  = bus.MemWrite && mmio_sel && !ram_sel;
    assign match    = (mtime == mtimecmp);
    assign irq_clr  = wr_mmio && (reg_sel == REG_STATUS) && bus.WriteData[0];

    // RAM is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[word_idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime    <= 32'd0;
            mtimecmp <= 32'hFFFF_FFFF;
            led_reg  <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_mmio && (reg_sel == REG_MTIME)) begin
                mtime <= bus.WriteData;
            end else begin
                mtime <= mtime + 32'd1;
            end
            if (wr_mmio && (reg_sel == REG_CMP)) begin
                mtimecmp <= bus.WriteData;
            end
            if (wr_mmio && (reg_sel == REG_LED)) begin
                led_reg <= bus.WriteData[LED_W-1:0];
            end
            // A match in the same cycle as a clear keeps the flag set.
            if (match) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.ReadData = 32'd0;
        if (ram_sel) begin
            bus.ReadData = mem[word_idx];
        end else if (mmio_sel) begin
            case (reg_sel)
                REG_MTIME:  bus.ReadData = mtime;
                REG_CMP:    bus.ReadData = mtimecmp;
                REG_LED:    bus.ReadData = 32'(led_reg);
                default:    bus.ReadData = {31'd0, irq};
            endcase
        end
    end

    assign leds      = led_reg;
    assign timer_irq = irq;

endmodule

`default_nettype wire

// File: tb/tb_riscv_dmem_responder.sv
// ============================================================================
// tb_riscv_dmem_responder : directed + random checks against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_riscv_dmem_responder;

    localparam int          DEPTH     = 64;
    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam int          LED_W     = 8;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic             clk = 1'b0;
    logic             reset;
    logic [LED_W-1:0] leds;
    logic             timer_irq;

    riscv_dmem_responder_if bus();

    riscv_dmem_responder #(
        .DEPTH    (DEPTH),
        .MMIO_BASE(BASE),
        .LED_W    (LED_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .leds     (leds),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0]      m_ram [DEPTH];
    bit               m_known [DEPTH];
    logic [31:0]      m_mtime;
    logic [31:0]      m_cmp;
    logic [LED_W-1:0] m_led;
    logic             m_irq;
    bit               started = 1'b0;

    function automatic bit in_window(input logic [31:0] a);
        return (a >= RAM_BYTES) && (a >= BASE) && ((a - BASE) < 32'd16);
    endfunction

    function automatic bit mmio_wr(input int r);
        return bus.MemWrite && in_window(bus.DataAdr) && (int'(bus.DataAdr[3:2]) == r);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a < RAM_BYTES) begin
            known = m_known[int'(a >> 2)];
            return m_ram[int'(a >> 2)];
        end
        if (in_window(a)) begin
            case (int'(a[3:2]))
                0:       return m_mtime;
                1:       return m_cmp;
                2:       return 32'(m_led);
                default: return {31'd0, m_irq};
            endcase
        end
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (bus.MemWrite && (bus.DataAdr < RAM_BYTES)) begin
            m_ram[int'(bus.DataAdr >> 2)]   <= bus.WriteData;
            m_known[int'(bus.DataAdr >> 2)] <= 1'b1;
        end
        if (reset) begin
            m_mtime <= 32'd0;
            m_cmp   <= 32'hFFFF_FFFF;
            m_led   <= '0;
            m_irq   <= 1'b0;
        end else begin
            m_mtime <= mmio_wr(0) ? bus.WriteData : m_mtime + 32'd1;
            m_cmp   <= mmio_wr(1) ? bus.WriteData : m_cmp;
            m_led   <= mmio_wr(2) ? bus.WriteData[LED_W-1:0] : m_led;
            if (m_mtime == m_cmp)
                m_irq <= 1'b1;
            else if (mmio_wr(3) && bus.WriteData[0])
                m_irq <= 1'b0;
        end
        started <= 1'b1;
    end

    // ---------------- literal expectations for the current cycle ----------------
    bit          lit_rd_v, lit_led_v, lit_irq_v;
    string       lit_rd_name, lit_led_name, lit_irq_name;
    logic [31:0] lit_rd, lit_led, lit_irq;

    // ---------------- compare process ----------------
    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", nm, got, want, $time);
        end
    endfunction

    always @(negedge clk) begin : compare
        logic [31:0] e;
        bit          k;
        if (started) begin
            e = model_read(bus.DataAdr, k);
            if (k) chk("read_vs_model", bus.ReadData, e);
            chk("leds_vs_model", 32'(leds), 32'(m_led));
            chk("irq_vs_model", 32'(timer_irq), 32'(m_irq));
            if (lit_rd_v)  chk(lit_rd_name, bus.ReadData, lit_rd);
            if (lit_led_v) chk(lit_led_name, 32'(leds), lit_led);
            if (lit_irq_v) chk(lit_irq_name, 32'(timer_irq), lit_irq);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rs, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset         = rs;
        bus.MemWrite  = we;
        bus.DataAdr   = a;
        bus.WriteData = d;
        lit_rd_v  = 1'b0;
        lit_led_v = 1'b0;
        lit_irq_v = 1'b0;
        #1;
    endtask

    task automatic exp_rd(input string nm, input logic [31:0] v);
        lit_rd_v = 1'b1; lit_rd_name = nm; lit_rd = v;
    endtask

    task automatic exp_led(input string nm, input logic [31:0] v);
        lit_led_v = 1'b1; lit_led_name = nm; lit_led = v;
    endtask

    task automatic exp_irq(input string nm, input logic [31:0] v);
        lit_irq_v = 1'b1; lit_irq_name = nm; lit_irq = v;
    endtask

    initial begin
        bit          hit;
        int          sel;
        bit          rs, we;
        logic [31:0] a, d;

        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'd0;
        bus.WriteData = 32'd0;
        lit_rd_v  = 1'b0;
        lit_led_v = 1'b0;
        lit_irq_v = 1'b0;

        // Reset values and free-running counter
        step(1, 0, 32'h100C, 0); exp_rd("rst_status", 32'd0);
        step(1, 0, 32'h1004, 0); exp_rd("rst_mtimecmp", 32'hFFFF_FFFF);
        exp_led("rst_leds", 32'd0); exp_irq("rst_irq", 32'd0);
        step(0, 0, 32'h1000, 0); exp_rd("mtime_post_reset", 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 32'h1000, 0);
            if (i == 5) exp_rd("mtime_plus5", 32'd5);
        end

        // Give every RAM word a known value
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 32'(i * 4), 32'hA500_0000 | 32'(i));

        // RAM store/load
        step(0, 1, 32'h10, 32'hDEAD_BEEF); exp_rd("ram_same_cycle_old", 32'hA500_0004);
        step(0, 0, 32'h10, 0);             exp_rd("ram_new", 32'hDEAD_BEEF);
        step(0, 0, 32'h13, 0);             exp_rd("ram_unaligned", 32'hDEAD_BEEF);
        step(0, 0, 32'h100, 0);            exp_rd("unmapped_read", 32'd0);

        // MTIME load and wrap; FFFF_FFFF also matches the reset MTIMECMP
        step(0, 1, 32'h1000, 32'hFFFF_FFFE);
        step(0, 0, 32'h1000, 0); exp_rd("mtime_loaded", 32'hFFFF_FFFE);
        step(0, 0, 32'h1000, 0); exp_rd("mtime_max", 32'hFFFF_FFFF);
        step(0, 0, 32'h1000, 0); exp_rd("mtime_wrap", 32'd0);
        exp_irq("irq_reset_cmp_match", 32'd1);

        // Interrupt timing
        step(0, 1, 32'h1004, 32'd20);
        step(0, 1, 32'h1000, 32'd10);
        step(0, 1, 32'h100C, 32'd1);
        step(0, 0, 32'h100C, 0); exp_rd("status_cleared", 32'd0); exp_irq("irq_cleared", 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 32'h1000, 0);
            if (bus.ReadData == 32'd20) begin
                hit = 1'b1;
                break;
            end
        end
        if (hit) exp_irq("irq_low_at_match", 32'd0);
        else     exp_rd("mtime_reach_20", 32'd20);
        step(0, 0, 32'h1000, 0); exp_rd("mtime_21", 32'd21); exp_irq("irq_rise", 32'd1);
        step(0, 0, 32'h1000, 0);
        step(0, 0, 32'h1000, 0); exp_irq("irq_sticky", 32'd1);
        step(0, 1, 32'h100C, 32'd0);
        step(0, 0, 32'h100C, 0); exp_rd("status_write0", 32'd1); exp_irq("irq_write0_keeps", 32'd1);
        step(0, 1, 32'h100C, 32'd1);
        step(0, 0, 32'h100C, 0); exp_irq("irq_clear", 32'd0);

        // Set/clear collision
        step(0, 1, 32'h1000, 32'd100);
        step(0, 1, 32'h1004, 32'd102);
        step(0, 0, 32'h1000, 0);
        step(0, 1, 32'h100C, 32'd1);
        step(0, 0, 32'h100C, 0); exp_rd("collision_status", 32'd1); exp_irq("set_wins", 32'd1);

        // LED and mid-operation reset
        step(0, 1, 32'h1008, 32'h1A5);
        step(0, 0, 32'h1008, 0); exp_led("led_write", 32'hA5); exp_rd("led_read", 32'hA5);
        step(1, 1, 32'h1008, 32'hFF);
        step(0, 0, 32'h1008, 0); exp_led("led_reset_wins", 32'd0);
        step(1, 1, 32'h20, 32'h1234_5678);
        step(0, 0, 32'h20, 0); exp_rd("ram_write_in_reset", 32'h1234_5678);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rs  = ($urandom_range(0, 99) == 0);
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            sel = int'($urandom_range(0, 99));
            if (sel < 40) begin
                a = 32'($urandom_range(0, DEPTH * 4 - 1));
            end else if (sel < 70) begin
                a = BASE + 32'($urandom_range(0, 15));
            end else if (sel < 80) begin
                case ($urandom_range(0, 3))
                    0:       a = RAM_BYTES + 32'($urandom_range(0, 255));
                    1:       a = BASE - 32'd4 + 32'($urandom_range(0, 3));
                    2:       a = BASE + 32'd16 + 32'($urandom_range(0, 3));
                    default: a = $urandom | 32'h8000_0000;
                endcase
            end else if (sel < 92) begin
                a  = BASE + 32'd4;
                we = 1'b1;
                d  = m_mtime + 32'($urandom_range(1, 4));
            end else begin
                a  = BASE + 32'd12;
                we = 1'b1;
                d  = 32'($urandom_range(0, 1));
            end
            step(rs, we, a, d);
        end

        step(0, 0, 32'h0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
